// File: rtl/reg_file_pkg.sv
// ----------------------------------------------------------------------------
// reg_file_pkg
//   Shared definitions for reg_file and its request/response front-end
//   reg_file_ctrl:
//     - default geometry of the register file (width, address bits, depth)
//     - state encoding of the reg_file_ctrl FSM
//     - address range helper used when a command is accepted
// ----------------------------------------------------------------------------
package reg_file_pkg;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_ADDRESS_WIDTH  = 4;
  localparam int DEF_REGISTER_DEPTH = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_READ    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } ctrl_state_t;

  // An address is out of range when it does not name an implemented register.
  // Both operands are zero-extended to 32 bits by the caller so the compare is
  // unsigned regardless of the address width.
  function automatic logic addr_out_of_range(input logic [31:0] addr,
                                             input logic [31:0] depth);
    return (addr >= depth);
  endfunction

endpackage : reg_file_pkg

// File: rtl/reg_file_ctrl.sv
// ----------------------------------------------------------------------------
// reg_file_ctrl
//   Request/response front-end for the single-port reg_file. Accepts one
//   read or write command at a time over a valid/ready handshake, performs
//   the access on the reg_file one-port interface and returns exactly one
//   response per command (read data or write acknowledge, plus an error flag
//   for addresses at or above REGISTER_DEPTH).
//
// Parameters
//   DATA_WIDTH     word width, must match reg_file
//   ADDRESS_WIDTH  address width, must match reg_file
//   REGISTER_DEPTH number of implemented registers (<= 2**ADDRESS_WIDTH)
//
// Ports
//   i_clk, i_rst          rising-edge clock, synchronous active-high reset
//   i_req_valid/o_req_ready, i_req_write, i_req_address, i_req_data
//                         command channel
//   o_rsp_valid/i_rsp_ready, o_rsp_write, o_rsp_error, o_rsp_data
//                         response channel
//   o_rf_write_enable, o_rf_read_enable, o_rf_address, o_rf_write_data,
//   i_rf_read_data        reg_file port (read data is registered in reg_file,
//                         valid one cycle after a sampled read enable)
// ----------------------------------------------------------------------------
module reg_file_ctrl
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int REGISTER_DEPTH = DEF_REGISTER_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst,

  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_write,
  input  logic [ADDRESS_WIDTH-1:0] i_req_address,
  input  logic [DATA_WIDTH-1:0]    i_req_data,

  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic                     o_rsp_write,
  output logic                     o_rsp_error,
  output logic [DATA_WIDTH-1:0]    o_rsp_data,

  output logic                     o_rf_write_enable,
  output logic                     o_rf_read_enable,
  output logic [ADDRESS_WIDTH-1:0] o_rf_address,
  output logic [DATA_WIDTH-1:0]    o_rf_write_data,
  input  logic [DATA_WIDTH-1:0]    i_rf_read_data
);

  ctrl_state_t state_q;
  ctrl_state_t state_d;

  // Command latch: captured once at the accept edge and held until the next
  // accept, so the reg_file address/data lines stay put while idle.
  logic                     cmd_write_q;
  logic [ADDRESS_WIDTH-1:0] cmd_address_q;
  logic [DATA_WIDTH-1:0]    cmd_data_q;

  // Response register: error is decided at accept time, data is either
  // cleared at accept (writes, errors) or loaded in CAPTURE (reads).
  logic                     rsp_error_q;
  logic [DATA_WIDTH-1:0]    rsp_data_q;

  logic                     req_accept;
  logic                     req_oor;

  // Accept is a function of state and valid only; the reset branch of every
  // register below has priority, so a command offered during reset is lost.
  assign req_accept = (state_q == S_IDLE) && i_req_valid;
  assign req_oor    = addr_out_of_range(32'(i_req_address), 32'(REGISTER_DEPTH));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          if (req_oor) begin
            // Out-of-range commands never touch reg_file.
            state_d = S_RESP;
          end else if (i_req_write) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_WRITE:   state_d = S_RESP;
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_RESP;
      S_RESP: begin
        if (i_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Command latch and response register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cmd_write_q   <= 1'b0;
      cmd_address_q <= '0;
      cmd_data_q    <= '0;
      rsp_error_q   <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      if (req_accept) begin
        cmd_write_q   <= i_req_write;
        cmd_address_q <= i_req_address;
        cmd_data_q    <= i_req_data;
        rsp_error_q   <= req_oor;
        rsp_data_q    <= '0;
      end else if (state_q == S_CAPTURE) begin
        // reg_file sampled the read enable at the previous edge, so its
        // registered output is valid during this cycle.
        rsp_data_q <= i_rf_read_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  // Every output is forced to 0 while i_rst is high, independent of the
  // (possibly unknown) register contents before the first reset edge.
  always_comb begin
    o_req_ready       = 1'b0;
    o_rsp_valid       = 1'b0;
    o_rsp_write       = 1'b0;
    o_rsp_error       = 1'b0;
    o_rsp_data        = '0;
    o_rf_write_enable = 1'b0;
    o_rf_read_enable  = 1'b0;
    o_rf_address      = '0;
    o_rf_write_data   = '0;
    if (!i_rst) begin
      o_rsp_write     = cmd_write_q;
      o_rsp_error     = rsp_error_q;
      o_rsp_data      = rsp_data_q;
      o_rf_address    = cmd_address_q;
      o_rf_write_data = cmd_data_q;
      unique case (state_q)
        S_IDLE:    o_req_ready       = 1'b1;
        S_WRITE:   o_rf_write_enable = 1'b1;
        S_READ:    o_rf_read_enable  = 1'b1;
        S_CAPTURE: ;
        S_RESP:    o_rsp_valid       = 1'b1;
        default:   ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Design invariants
  // --------------------------------------------------------------------------
  // The single reg_file port can do one access per cycle.
  a_enables_exclusive : assert property (@(posedge i_clk) disable iff (i_rst)
    !(o_rf_write_enable && o_rf_read_enable));

  // A stalled response must not change under the consumer.
  a_rsp_stable : assert property (@(posedge i_clk) disable iff (i_rst)
    (state_q == S_RESP && !i_rsp_ready) |=>
      (state_q == S_RESP && $stable(rsp_data_q) && $stable(rsp_error_q)
       && $stable(cmd_write_q)));

  // Command accepted only from IDLE; no new command while a response waits.
  a_no_accept_in_resp : assert property (@(posedge i_clk) disable iff (i_rst)
    (state_q == S_RESP) |-> !o_req_ready);

endmodule : reg_file_ctrl

// File: tb/tb_reg_file_ctrl.sv
// ----------------------------------------------------------------------------
// tb_reg_file_ctrl
//   Bench for reg_file_ctrl. Instance dut drives a behavioural single-port
//   register file (registered read data, active-low reset); instance dut_b is
//   built with REGISTER_DEPTH=12 to exercise the out-of-range path.
// ----------------------------------------------------------------------------
module tb_reg_file_ctrl;
  import reg_file_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic          rst, rf_rst_n;

  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_address;
  logic [DW-1:0] req_data;
  logic          rsp_valid, rsp_ready, rsp_write, rsp_error;
  logic [DW-1:0] rsp_data;
  logic          rf_we, rf_re;
  logic [AW-1:0] rf_address;
  logic [DW-1:0] rf_wdata, rf_rdata;

  logic          req_valid_b, req_ready_b, req_write_b;
  logic [AW-1:0] req_address_b;
  logic [DW-1:0] req_data_b;
  logic          rsp_valid_b, rsp_ready_b, rsp_write_b, rsp_error_b;
  logic [DW-1:0] rsp_data_b;
  logic          rf_we_b, rf_re_b;
  logic [AW-1:0] rf_address_b;
  logic [DW-1:0] rf_wdata_b;
  logic [DW-1:0] rf_rdata_b;

  reg_file_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .REGISTER_DEPTH(16)) dut (
    .i_clk(i_clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
    .i_req_address(req_address), .i_req_data(req_data),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_write(rsp_write),
    .o_rsp_error(rsp_error), .o_rsp_data(rsp_data),
    .o_rf_write_enable(rf_we), .o_rf_read_enable(rf_re),
    .o_rf_address(rf_address), .o_rf_write_data(rf_wdata),
    .i_rf_read_data(rf_rdata)
  );

  reg_file_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .REGISTER_DEPTH(12)) dut_b (
    .i_clk(i_clk), .i_rst(rst),
    .i_req_valid(req_valid_b), .o_req_ready(req_ready_b), .i_req_write(req_write_b),
    .i_req_address(req_address_b), .i_req_data(req_data_b),
    .o_rsp_valid(rsp_valid_b), .i_rsp_ready(rsp_ready_b), .o_rsp_write(rsp_write_b),
    .o_rsp_error(rsp_error_b), .o_rsp_data(rsp_data_b),
    .o_rf_write_enable(rf_we_b), .o_rf_read_enable(rf_re_b),
    .o_rf_address(rf_address_b), .o_rf_write_data(rf_wdata_b),
    .i_rf_read_data(rf_rdata_b)
  );

  // Non-zero read data on dut_b so a wrongly captured value is visible.
  assign rf_rdata_b = 32'hDEAD_BEEF;

  // Behavioural reg_file: one port, registered read data.
  logic [DW-1:0] rf_mem [16];
  always @(posedge i_clk) begin
    if (!rf_rst_n) begin
      for (int k = 0; k < 16; k++) rf_mem[k] <= '0;
      rf_rdata <= '0;
    end else begin
      if (rf_we) rf_mem[rf_address] <= rf_wdata;
      if (rf_re) rf_rdata <= rf_mem[rf_address];
    end
  end

  // Continuous port monitors.
  int both_en_cnt = 0;
  int b_en_cnt    = 0;
  int rd_pulses   = 0;
  int wr_pulses   = 0;
  always @(negedge i_clk) begin
    if (rf_we === 1'b1 && rf_re === 1'b1) both_en_cnt++;
    if (rf_re === 1'b1) rd_pulses++;
    if (rf_we === 1'b1) wr_pulses++;
    if (rf_we_b === 1'b1 || rf_re_b === 1'b1) b_en_cnt++;
  end

  typedef struct {
    logic          write;
    logic          error;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [16];
  int            errors = 0;
  int            checks = 0;
  int            last_pre = 0;
  int            exp_rd = 0;
  int            exp_wr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer a command from a negedge; returns at the negedge after the accept.
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    int   n = 0;
    req_valid = 1'b1; req_write = w; req_address = a; req_data = d;
    #1;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge i_clk); #1; n++;
    end
    check("req_ready_wait", {31'b0, req_ready}, 32'd1);
    last_pre = cyc;
    @(negedge i_clk);
    req_valid = 1'b0;
    req_data  = $urandom;
    if (w) begin
      ref_mem[a] = d;
      e.write = 1'b1; e.error = 1'b0; e.data = '0;
      exp_wr++;
    end else begin
      e.write = 1'b0; e.error = 1'b0; e.data = ref_mem[a];
      exp_rd++;
    end
    sb.push_back(e);
  endtask

  // Wait for the response, compare with the scoreboard, optionally stall it.
  task automatic recv(input int exp_lat, input int bp, input string tag);
    exp_t e;
    int   n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge i_clk); n++;
    end
    check({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
    check({tag, "_latency"}, cyc - last_pre, exp_lat);
    check({tag, "_sb_nonempty"}, {31'b0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_write"}, {31'b0, rsp_write}, {31'b0, e.write});
      check({tag, "_error"}, {31'b0, rsp_error}, {31'b0, e.error});
      check({tag, "_data"},  rsp_data, e.data);
      for (int i = 0; i < bp; i++) begin
        rsp_ready = 1'b0;
        @(negedge i_clk);
        check({tag, "_bp_valid"}, {31'b0, rsp_valid}, 32'd1);
        check({tag, "_bp_data"},  rsp_data, e.data);
        check({tag, "_bp_write"}, {31'b0, rsp_write}, {31'b0, e.write});
        check({tag, "_bp_error"}, {31'b0, rsp_error}, {31'b0, e.error});
        check({tag, "_bp_req_ready"}, {31'b0, req_ready}, 32'd0);
      end
    end
    rsp_ready = 1'b1;
    @(negedge i_clk);
    check({tag, "_after_valid"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_after_idle"},  {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int p;
    int prev;
    int n;
    rst = 1'b1; rf_rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_data = '0;
    rsp_ready = 1'b0;
    req_valid_b = 1'b0; req_write_b = 1'b0; req_address_b = '0; req_data_b = '0;
    rsp_ready_b = 1'b0;
    for (int k = 0; k < 16; k++) ref_mem[k] = '0;

    // Reset state
    repeat (3) @(negedge i_clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_data",  rsp_data, 32'd0);
    check("rst_rf_we",     {31'b0, rf_we}, 32'd0);
    check("rst_rf_re",     {31'b0, rf_re}, 32'd0);
    check("rst_rf_addr",   {28'b0, rf_address}, 32'd0);
    check("rst_rf_wdata",  rf_wdata, 32'd0);
    rst = 1'b0; rf_rst_n = 1'b1;
    #1;
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);

    // Unwritten register
    send(1'b0, 4'd15, 32'hFFFF_FFFF); recv(3, 0, "unwritten15");

    // Write then read
    send(1'b1, 4'd12, 32'h0000_000F); recv(2, 0, "wr12");
    check("hold_rf_addr",  {28'b0, rf_address}, 32'd12);
    check("hold_rf_wdata", rf_wdata, 32'h0000_000F);
    send(1'b0, 4'd12, 32'h0);         recv(3, 0, "rd12");

    // Out of range on the depth-12 instance (boundary 12 and 13)
    req_valid_b = 1'b1; req_write_b = 1'b0; req_address_b = 4'd13; req_data_b = 32'h1357_9BDF;
    #1;
    check("oor_req_ready", {31'b0, req_ready_b}, 32'd1);
    p = cyc;
    @(negedge i_clk);
    req_valid_b = 1'b0;
    check("oor_rd_latency", cyc - p, 32'd1);
    check("oor_rd_valid", {31'b0, rsp_valid_b}, 32'd1);
    check("oor_rd_error", {31'b0, rsp_error_b}, 32'd1);
    check("oor_rd_write", {31'b0, rsp_write_b}, 32'd0);
    check("oor_rd_data",  rsp_data_b, 32'd0);
    rsp_ready_b = 1'b1;
    @(negedge i_clk);
    check("oor_rd_after_valid", {31'b0, rsp_valid_b}, 32'd0);
    req_valid_b = 1'b1; req_write_b = 1'b1; req_address_b = 4'd12;
    @(negedge i_clk);
    req_valid_b = 1'b0;
    check("oor_wr_valid", {31'b0, rsp_valid_b}, 32'd1);
    check("oor_wr_error", {31'b0, rsp_error_b}, 32'd1);
    check("oor_wr_write", {31'b0, rsp_write_b}, 32'd1);
    check("oor_wr_data",  rsp_data_b, 32'd0);
    @(negedge i_clk);
    check("oor_wr_after_valid", {31'b0, rsp_valid_b}, 32'd0);

    // Response backpressure
    send(1'b1, 4'd3, 32'hA5A5_A5A5); recv(2, 0, "wr3");
    send(1'b0, 4'd3, 32'h0);         recv(3, 5, "bp_rd3");

    // Reset in CAPTURE
    send(1'b1, 4'd7, 32'h1234_5678); recv(2, 0, "wr7");
    send(1'b0, 4'd7, 32'h0);
    check("abort_read_en", {31'b0, rf_re}, 32'd1);
    @(negedge i_clk);
    check("capture_re", {31'b0, rf_re}, 32'd0);
    check("capture_we", {31'b0, rf_we}, 32'd0);
    rst = 1'b1;
    @(negedge i_clk);
    check("abort_req_ready", {31'b0, req_ready}, 32'd0);
    check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("abort_rsp_data",  rsp_data, 32'd0);
    check("abort_rsp_write", {31'b0, rsp_write}, 32'd0);
    check("abort_rf_addr",   {28'b0, rf_address}, 32'd0);
    check("abort_rf_wdata",  rf_wdata, 32'd0);
    sb.delete();
    rst = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge i_clk);
      if (rsp_valid === 1'b1) n++;
    end
    check("abort_no_rsp", n, 32'd0);
    send(1'b0, 4'd7, 32'h0); recv(3, 0, "after_abort_rd7");

    // Back-to-back stream
    prev = 0;
    for (int a = 0; a < 16; a++) begin
      send(1'b1, AW'(a), 32'(a) * 32'h1111_1111);
      p = last_pre;
      recv(2, 0, "stream_wr");
      if (a > 0) check("stream_wr_period", p - prev, 32'd3);
      prev = p;
    end
    for (int a = 0; a < 16; a++) begin
      send(1'b0, AW'(a), 32'h0);
      p = last_pre;
      recv(3, 0, "stream_rd");
      if (a > 0) check("stream_rd_period", p - prev, 32'd4);
      prev = p;
    end

    // Port-level totals
    check("enables_exclusive", both_en_cnt, 32'd0);
    check("oor_no_access",     b_en_cnt, 32'd0);
    check("read_pulses",       rd_pulses, exp_rd);
    check("write_pulses",      wr_pulses, exp_wr);
    check("sb_drained",        32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_reg_file_ctrl
